// File: rtl/debug_key_pkg.sv
// -----------------------------------------------------------------------------
// debug_key_pkg
// Shared definitions for the debug key conditioner:
//   - key_state_e    : per-key channel state
//   - DEF_*          : default timing constants (cycles of the 50 MHz clock)
//   - KEY_PLAY/STEP  : bit index of each key in the 2-bit key vectors
//   - max3()         : helper used to size the shared timing counter
// -----------------------------------------------------------------------------
package debug_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYC  = 1000000;   // 20 ms at 50 MHz
  localparam int DEF_REPEAT_DELAY  = 25000000;  // 500 ms at 50 MHz
  localparam int DEF_REPEAT_PERIOD = 5000000;   // 100 ms at 50 MHz

  localparam int NUM_KEYS = 2;
  localparam int KEY_PLAY = 0;
  localparam int KEY_STEP = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debug_key_channel.sv
// -----------------------------------------------------------------------------
// debug_key_channel
// One conditioned key: 2-FF synchronizer, debounce FSM, optional auto-repeat.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_key_n  : raw key, active-low, asynchronous to i_clk
//   o_pulse  : registered one-cycle pulse per accepted press (and per repeat)
//   o_level  : debounced pressed level, 1 = pressed
// Parameters:
//   DEBOUNCE_CYC  : stable cycles needed to accept a press or a release
//   REPEAT_DELAY  : cycles held before auto-repeat starts (REPEAT_EN=1 only)
//   REPEAT_PERIOD : cycles between repeat pulses
//   REPEAT_EN     : 1 enables the HELD -> REPEAT path
// -----------------------------------------------------------------------------
module debug_key_channel
  import debug_key_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pulse,
  output logic o_level
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  // Terminal counts: the counter holds (cycles already seen - 1) when the
  // current cycle completes the required run.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             pressed;
  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             pulse_q;
  logic             level_q;

  // Synchronizer resets to the released (high) raw value so a key held
  // through reset is seen as a fresh press once reset lifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_key_n};
    end
  end

  assign pressed = ~sync_q[1];

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign cnt_inc_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_q <= ST_PRESS_DB;
            cnt_q   <= '0;
          end
        end

        ST_PRESS_DB: begin
          if (!pressed) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q >= DB_LAST) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        ST_HELD: begin
          if (!pressed) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end else if (REPEAT_EN) begin
            if (cnt_q >= RD_LAST) begin
              state_q <= ST_REPEAT;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
        end

        ST_REPEAT: begin
          if (!pressed) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end else if (cnt_q >= RP_LAST) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        ST_RELEASE_DB: begin
          // A bounce back to pressed resumes HELD silently and restarts the
          // repeat delay from zero.
          if (pressed) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q >= DB_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_pulse = pulse_q;
  assign o_level = level_q;

endmodule

// File: rtl/debug_key_conditioner.sv
// -----------------------------------------------------------------------------
// debug_key_conditioner
// Conditions the two board debug keys into clean control pulses.
//   i_clk            : system clock, 50 MHz
//   i_rst_n          : asynchronous active-low reset
//   i_key_n[1:0]     : raw keys, active-low (bit0 play/pause, bit1 step)
//   o_play_pause     : one-cycle pulse per accepted key0 press
//   o_frame_by_frame : one-cycle pulse per accepted key1 press, with auto-repeat
//   o_key_level[1:0] : debounced pressed level per key, 1 = pressed
// -----------------------------------------------------------------------------
module debug_key_conditioner
  import debug_key_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_key_n,
  output logic       o_play_pause,
  output logic       o_frame_by_frame,
  output logic [1:0] o_key_level
);

  logic [NUM_KEYS-1:0] pulse;

  // Channels are fully independent; only the step key auto-repeats.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
    debug_key_channel #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (gi == KEY_STEP)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key_n (i_key_n[gi]),
      .o_pulse (pulse[gi]),
      .o_level (o_key_level[gi])
    );
  end

  assign o_play_pause     = pulse[KEY_PLAY];
  assign o_frame_by_frame = pulse[KEY_STEP];

endmodule

// File: tb/tb_debug_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_debug_key_conditioner
// Directed bench for debug_key_conditioner with short timing parameters.
// Time reference: cyc counts rising edges. A key driven while cyc == T reaches
// p at edge T+2, so its press pulse is expected at cyc == T+11 (p + 9).
// -----------------------------------------------------------------------------
module tb_debug_key_conditioner;

  localparam int DB  = 8;
  localparam int RD  = 40;
  localparam int RP  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_n;
  logic       play_pause;
  logic       frame_by_frame;
  logic [1:0] key_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int   pp_q[$];
  int   fb_q[$];
  int   consec = 0;
  logic pp_prev = 1'b0;
  logic fb_prev = 1'b0;
  logic [1:0] lvl_seen = 2'b00;

  debug_key_conditioner #(
    .DEBOUNCE_CYC  (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_key_n          (key_n),
    .o_play_pause     (play_pause),
    .o_frame_by_frame (frame_by_frame),
    .o_key_level      (key_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle stamp of every pulse cycle, and watch for back-to-back pulses.
  always @(negedge clk) begin
    if (play_pause)     pp_q.push_back(cyc);
    if (frame_by_frame) fb_q.push_back(cyc);
    if ((play_pause && pp_prev) || (frame_by_frame && fb_prev)) consec++;
    pp_prev = play_pause;
    fb_prev = frame_by_frame;
    lvl_seen = lvl_seen | key_level;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic clear_log();
    pp_q.delete();
    fb_q.delete();
    lvl_seen = 2'b00;
  endtask

  initial begin
    int t0;
    int r;

    rst_n = 1'b0;
    key_n = 2'b11;
    tick(3);
    check("rst_pp",  int'(play_pause), 0);
    check("rst_fb",  int'(frame_by_frame), 0);
    check("rst_lvl", int'(key_level), 0);
    rst_n = 1'b1;
    tick(5);
    clear_log();

    // Key0 held 100 cycles: one pulse, level tracks press/release debounce.
    t0 = cyc;
    key_n[0] = 1'b0;
    tick(10);
    check("s1_lvl_before", int'(key_level[0]), 0);
    tick(1);
    check("s1_lvl_set", int'(key_level[0]), 1);
    tick(89);
    key_n[0] = 1'b1;
    tick(10);
    check("s1_lvl_hold", int'(key_level[0]), 1);
    tick(1);
    check("s1_lvl_clr", int'(key_level[0]), 0);
    tick(20);
    check("s1_pp_n",  pp_q.size(), 1);
    check("s1_pp_t",  q_at(pp_q, 0), t0 + DB + 3);
    check("s1_fb_n",  fb_q.size(), 0);
    $display("[TB] key0 hold 100: pp pulses=%0d at %0d", pp_q.size(), q_at(pp_q, 0) - t0);
    clear_log();

    // Key1 glitch train 5 low / 3 high / 5 low: nothing accepted.
    key_n[1] = 1'b0; tick(5);
    key_n[1] = 1'b1; tick(3);
    key_n[1] = 1'b0; tick(5);
    key_n[1] = 1'b1; tick(30);
    check("s2_fb_n", fb_q.size(), 0);
    check("s2_lvl",  int'(lvl_seen[1]), 0);
    $display("[TB] key1 glitch: fb pulses=%0d level_seen=%0d", fb_q.size(), lvl_seen[1]);
    clear_log();

    // Key1 held 75 cycles: press pulse, first repeat, then two periodic repeats.
    t0 = cyc;
    key_n[1] = 1'b0;
    tick(40);
    check("s3_lvl", int'(key_level[1]), 1);
    tick(35);
    key_n[1] = 1'b1;
    tick(30);
    check("s3_fb_n",  fb_q.size(), 4);
    check("s3_fb_t0", q_at(fb_q, 0), t0 + 11);
    check("s3_fb_t1", q_at(fb_q, 1), t0 + 11 + RD);
    check("s3_fb_t2", q_at(fb_q, 2), t0 + 11 + RD + RP);
    check("s3_fb_t3", q_at(fb_q, 3), t0 + 11 + RD + 2 * RP);
    check("s3_pp_n",  pp_q.size(), 0);
    $display("[TB] key1 hold 75: fb pulses=%0d", fb_q.size());
    clear_log();

    // Key1 released 4 cycles while HELD: no new pulse, repeat delay restarts.
    t0 = cyc;
    key_n[1] = 1'b0;
    tick(20);
    key_n[1] = 1'b1;
    tick(4);
    check("s4_lvl_gap", int'(key_level[1]), 1);
    key_n[1] = 1'b0;
    tick(46);
    key_n[1] = 1'b1;
    tick(30);
    check("s4_fb_n",  fb_q.size(), 2);
    check("s4_fb_t0", q_at(fb_q, 0), t0 + 11);
    check("s4_fb_t1", q_at(fb_q, 1), t0 + 27 + RD);
    $display("[TB] key1 bounce in HELD: fb pulses=%0d second at %0d", fb_q.size(), q_at(fb_q, 1) - t0);
    clear_log();

    // Both keys pressed together: pulses coincide.
    t0 = cyc;
    key_n = 2'b00;
    tick(20);
    check("s5_lvl", int'(key_level), 3);
    key_n = 2'b11;
    tick(30);
    check("s5_pp_n", pp_q.size(), 1);
    check("s5_fb_n", fb_q.size(), 1);
    check("s5_pp_t", q_at(pp_q, 0), t0 + 11);
    check("s5_fb_t", q_at(fb_q, 0), t0 + 11);
    $display("[TB] both keys: pp at %0d fb at %0d", q_at(pp_q, 0) - t0, q_at(fb_q, 0) - t0);
    clear_log();

    // Reset mid-REPEAT with key1 still held: quiet in reset, one pulse after.
    key_n[1] = 1'b0;
    tick(55);
    rst_n = 1'b0;
    #1;
    check("s6_rst_fb",  int'(frame_by_frame), 0);
    check("s6_rst_lvl", int'(key_level), 0);
    tick(3);
    check("s6_rst_lvl2", int'(key_level), 0);
    clear_log();
    rst_n = 1'b1;
    r = cyc;
    tick(40);
    check("s6_fb_n", fb_q.size(), 1);
    check("s6_fb_t", q_at(fb_q, 0), r + 11);
    check("s6_pp_n", pp_q.size(), 0);
    $display("[TB] reset in REPEAT: fb pulses=%0d at %0d after release", fb_q.size(), q_at(fb_q, 0) - r);
    key_n[1] = 1'b1;
    tick(30);

    check("no_consec", consec, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
